// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: derives PC/IF-ID/ID-EX/EX-MEM enables, flushes and
// bubbles from load-use hazards, EX-resolved control transfers and data-memory waits.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       idRs,
    input  logic [2:0]       idRt,
    input  logic             idUsesRs,
    input  logic             idUsesRt,
    input  logic             exMemRead,
    input  logic             exRegWrite,
    input  logic [2:0]       exWriteReg,
    input  logic             exTaken,
    input  logic             memBusy,
    input  logic             haltWb,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexWrite,
    output logic             idexBubble,
    output logic             exmemWrite,
    output logic             halted,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             halted_q, halted_d;
    logic             load_use;
    logic             flush_inc;

    assign load_use = exMemRead & exRegWrite &
                      ((idUsesRs & (idRs == exWriteReg)) |
                       (idUsesRt & (idRt == exWriteReg)));

    // Decode: freeze > control-transfer flush > load-use bubble > normal advance
    always_comb begin
        state_d    = state_q;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b0;
        idexWrite  = 1'b0;
        idexBubble = 1'b0;
        exmemWrite = 1'b0;
        flush_inc  = 1'b0;

        if (!rst) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    if (memBusy) begin
                        state_d = MEM_WAIT;
                    end else begin
                        state_d = RUN;
                        if (haltWb) begin
                            pcWrite    = 1'b1;
                            ifidWrite  = 1'b1;
                            idexWrite  = 1'b1;
                            exmemWrite = 1'b1;
                            state_d    = HALTED;
                        end else if (exTaken) begin
                            pcWrite    = 1'b1;
                            ifidWrite  = 1'b1;
                            ifidFlush  = 1'b1;
                            idexWrite  = 1'b1;
                            idexBubble = 1'b1;
                            exmemWrite = 1'b1;
                            flush_inc  = 1'b1;
                        end else if (load_use) begin
                            idexWrite  = 1'b1;
                            idexBubble = 1'b1;
                            exmemWrite = 1'b1;
                        end else begin
                            pcWrite    = 1'b1;
                            ifidWrite  = 1'b1;
                            idexWrite  = 1'b1;
                            exmemWrite = 1'b1;
                        end
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating performance counters; frozen once halted
    always_comb begin
        stall_d  = stall_q;
        flush_d  = flush_q;
        halted_d = (state_d == HALTED);
        if (rst && (state_q != HALTED)) begin
            if (!pcWrite && (stall_q != {CNT_W{1'b1}}))
                stall_d = stall_q + CNT_W'(1);
            if (flush_inc && (flush_q != {CNT_W{1'b1}}))
                flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            stall_q  <= '0;
            flush_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
        end
    end

    assign halted     = halted_q;
    assign stallCount = stall_q;
    assign flushCount = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle vector table through a scoreboard queue,
// plus saturation and mid-freeze asynchronous reset sequences.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  idRs, idRt, exWriteReg;
    logic        idUsesRs, idUsesRt, exMemRead, exRegWrite, exTaken, memBusy, haltWb;
    logic        pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, halted;
    logic [15:0] stallCount, flushCount;
    logic        pcWrite4, ifidWrite4, ifidFlush4, idexWrite4, idexBubble4, exmemWrite4, halted4;
    logic [3:0]  stallCount4, flushCount4;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRegWrite(exRegWrite),
        .exWriteReg(exWriteReg), .exTaken(exTaken), .memBusy(memBusy), .haltWb(haltWb),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexWrite(idexWrite), .idexBubble(idexBubble), .exmemWrite(exmemWrite),
        .halted(halted), .stallCount(stallCount), .flushCount(flushCount)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
        .idUsesRt(idUsesRt), .exMemRead(exMemRead), .exRegWrite(exRegWrite),
        .exWriteReg(exWriteReg), .exTaken(exTaken), .memBusy(memBusy), .haltWb(haltWb),
        .pcWrite(pcWrite4), .ifidWrite(ifidWrite4), .ifidFlush(ifidFlush4),
        .idexWrite(idexWrite4), .idexBubble(idexBubble4), .exmemWrite(exmemWrite4),
        .halted(halted4), .stallCount(stallCount4), .flushCount(flushCount4)
    );

    // ctl = {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemWrite, halted}
    localparam logic [6:0] C_RST  = 7'b0010100;
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_FRZ  = 7'b0000000;
    localparam logic [6:0] C_FLU  = 7'b1111110;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_HLT  = 7'b0000001;

    typedef struct {
        logic       r;
        logic [2:0] rs, rt, wr;
        logic       urs, urt, mr, rw, tk, mb, hw;
        logic [6:0] ctl;
        int         s, f;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [2:0] rs, input logic [2:0] rt,
                                input logic urs, input logic urt, input logic mr,
                                input logic rw, input logic [2:0] wr, input logic tk,
                                input logic mb, input logic hw, input logic [6:0] ctl,
                                input int s, input int f);
        vec_t v;
        v.r = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.rw = rw;
        v.wr = wr; v.tk = tk; v.mb = mb; v.hw = hw; v.ctl = ctl; v.s = s; v.f = f;
        return v;
    endfunction

    function automatic vec_t idle(input logic [6:0] ctl, input int s, input int f);
        return mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ctl, s, f);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s vec %0d: actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic compare_front(input int idx);
        vec_t e;
        int   sat;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", idx, 0, 1);
            return;
        end
        e   = exp_q.pop_front();
        sat = (e.s > 15) ? 15 : e.s;
        chk("ctl", idx, int'({pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble,
                              exmemWrite, halted}), int'(e.ctl));
        chk("stallCount", idx, int'(stallCount), e.s);
        chk("flushCount", idx, int'(flushCount), e.f);
        chk("ctl_w4", idx, int'({pcWrite4, ifidWrite4, ifidFlush4, idexWrite4, idexBubble4,
                                 exmemWrite4, halted4}), int'(e.ctl));
        chk("stallCount_w4", idx, int'(stallCount4), sat);
        chk("flushCount_w4", idx, int'(flushCount4), (e.f > 15) ? 15 : e.f);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        rst = v.r; idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt;
        exMemRead = v.mr; exRegWrite = v.rw; exWriteReg = v.wr;
        exTaken = v.tk; memBusy = v.mb; haltWb = v.hw;
        exp_q.push_back(v);
        @(negedge clk);
        compare_front(idx);
    endtask

    initial begin
        rst = 1'b0; idRs = '0; idRt = '0; exWriteReg = '0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        exMemRead = 1'b0; exRegWrite = 1'b0; exTaken = 1'b0; memBusy = 1'b0; haltWb = 1'b0;

        tbl.push_back(mk(1'b0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, C_RST, 0, 0));
        tbl.push_back(mk(1'b0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, C_RST, 0, 0));
        tbl.push_back(idle(C_NORM, 0, 0));
        tbl.push_back(idle(C_NORM, 0, 0));
        // load-use via rs, then the same producer with the consumer not reading it
        tbl.push_back(mk(1'b1, 3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 0, 0, 0, C_LU, 0, 0));
        tbl.push_back(idle(C_NORM, 1, 0));
        tbl.push_back(mk(1'b1, 3'd3, 3'd5, 0, 1, 1, 1, 3'd3, 0, 0, 0, C_NORM, 1, 0));
        tbl.push_back(mk(1'b1, 3'd0, 3'd3, 0, 1, 1, 1, 3'd3, 0, 0, 0, C_LU, 1, 0));
        tbl.push_back(mk(1'b1, 3'd3, 3'd3, 1, 1, 1, 0, 3'd3, 0, 0, 0, C_NORM, 2, 0));
        // taken transfer overrides a wrong-path load-use
        tbl.push_back(mk(1'b1, 3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 1, 0, 0, C_FLU, 2, 0));
        tbl.push_back(idle(C_NORM, 2, 1));
        // four-cycle freeze with exTaken held, flush once on release
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 1, 0, C_FRZ, 2 + k, 1));
        tbl.push_back(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 0, 0, C_FLU, 6, 1));
        tbl.push_back(idle(C_NORM, 6, 2));
        // freeze released into a load-use
        tbl.push_back(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, C_FRZ, 6, 2));
        tbl.push_back(mk(1'b1, 3'd2, 3'd0, 1, 0, 1, 1, 3'd2, 0, 0, 0, C_LU, 7, 2));
        tbl.push_back(idle(C_NORM, 8, 2));
        // halt ignored during freeze, then committed
        tbl.push_back(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 1, C_FRZ, 8, 2));
        tbl.push_back(idle(C_NORM, 9, 2));
        tbl.push_back(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 1, C_NORM, 9, 2));
        tbl.push_back(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 1, 1, C_HLT, 9, 2));
        tbl.push_back(mk(1'b1, 3'd4, 3'd0, 1, 0, 1, 1, 3'd4, 0, 0, 0, C_HLT, 9, 2));
        tbl.push_back(mk(1'b0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, C_RST, 0, 0));
        tbl.push_back(idle(C_NORM, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // saturation: the 4-bit instance clamps at 15 while the 16-bit one keeps counting
        for (int i = 0; i < 20; i++)
            apply(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, C_FRZ, i, 0), 100 + i);
        apply(idle(C_NORM, 20, 0), 120);
        apply(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, C_FRZ, 20, 0), 121);
        apply(mk(1'b1, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, C_FRZ, 21, 0), 122);

        // asynchronous reset asserted mid-freeze, between clock edges
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_ctl", 123, int'({pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble,
                                        exmemWrite, halted}), int'(C_RST));
        chk("async_rst_stall", 123, int'(stallCount), 0);
        chk("async_rst_stall_w4", 123, int'(stallCount4), 0);
        apply(mk(1'b0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, C_RST, 0, 0), 124);
        apply(idle(C_NORM, 0, 0), 125);
        apply(idle(C_NORM, 0, 0), 126);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
